// File: rtl/cond_pkg.sv
// Shared types for the execute-stage condition logic: condition codes,
// NZCV bit positions and a packed flag struct.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Pack individual flag bits into the architectural {N,Z,C,V} order.
  function automatic flags_t pack_flags(input logic n, input logic z,
                                        input logic c, input logic v);
    flags_t f;
    f.n = n;
    f.z = z;
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition evaluator: condition field against NZCV.
// Cond=NV is a build-time choice between never and always.
module cond_eval
  import cond_pkg::*;
#(
  parameter int NV_EXEC = 0
) (
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condex
);

  flags_t w_f;
  logic   w_ge;
  logic   w_hi;

  assign w_f  = flags_t'(i_flags);
  assign w_ge = (w_f.n == w_f.v);
  assign w_hi = w_f.c & ~w_f.z;

  always_comb begin
    o_condex = 1'b0;
    case (cond_t'(i_cond))
      EQ:      o_condex = w_f.z;
      NE:      o_condex = ~w_f.z;
      CS:      o_condex = w_f.c;
      CC:      o_condex = ~w_f.c;
      MI:      o_condex = w_f.n;
      PL:      o_condex = ~w_f.n;
      VS:      o_condex = w_f.v;
      VC:      o_condex = ~w_f.v;
      HI:      o_condex = w_hi;
      LS:      o_condex = ~w_hi;
      GE:      o_condex = w_ge;
      LT:      o_condex = ~w_ge;
      GT:      o_condex = ~w_f.z & w_ge;
      LE:      o_condex = ~(~w_f.z & w_ge);
      AL:      o_condex = 1'b1;
      NV:      o_condex = (NV_EXEC != 0);
      default: o_condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_pipe.sv
// Execute-stage condition unit: qualifies control writes, owns the NZCV
// register with grouped write enables, and keeps a shadow flag stack.
module condlogic_pipe
  import cond_pkg::*;
#(
  parameter int FLAG_GROUPS = 2,
  parameter int DEPTH       = 4,
  parameter int OUT_REG     = 0,
  parameter int NV_EXEC     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Valid,
  input  logic                       Stall,
  input  logic                       Flush,
  input  logic [3:0]                 Cond,
  input  logic [3:0]                 ALUFlags,
  input  logic [FLAG_GROUPS-1:0]     FlagW,
  input  logic                       PCS,
  input  logic                       RegW,
  input  logic                       MemW,
  input  logic                       Save,
  input  logic                       Restore,
  output logic                       PCSrc,
  output logic                       RegWrite,
  output logic                       MemWrite,
  output logic                       CondEx,
  output logic [3:0]                 Flags,
  output logic [$clog2(DEPTH+1)-1:0] StackCount,
  output logic                       StackErr
);

  localparam int CW = $clog2(DEPTH + 1);
  // Stack storage is rounded up to a power of two so the count bits index it directly.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SD = 1 << IW;
  localparam int GB = 4 / FLAG_GROUPS;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (!(FLAG_GROUPS == 1 || FLAG_GROUPS == 2 || FLAG_GROUPS == 4)) begin : g_bad_groups
    $error("condlogic_pipe: FLAG_GROUPS must be 1, 2 or 4");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("condlogic_pipe: DEPTH must be in 1..16");
  end

  logic [3:0]    r_flags;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic [3:0]    r_stack [SD];

  logic          w_condex;
  logic          w_go;
  logic          w_pcsrc;
  logic          w_regwrite;
  logic          w_memwrite;
  logic [3:0]    w_alu_flags;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_err;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_pop_idx;
  flags_t        w_flags_s;

  cond_eval #(
    .NV_EXEC (NV_EXEC)
  ) u_cond_eval (
    .i_cond   (Cond),
    .i_flags  (r_flags),
    .o_condex (w_condex)
  );

  assign w_go       = Valid & ~Stall & ~Flush & w_condex;
  assign w_pcsrc    = PCS  & w_go;
  assign w_regwrite = RegW & w_go;
  assign w_memwrite = MemW & w_go;

  // Each flag bit follows the write enable of the group it belongs to.
  for (genvar gi = 0; gi < 4; gi++) begin : g_flagw
    assign w_alu_flags[gi] = (FlagW[gi / GB] & w_go) ? ALUFlags[gi] : r_flags[gi];
  end

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_push     = Save & ~Restore & ~w_full;
  assign w_pop      = Restore & ~Save & ~w_empty;
  assign w_err      = (Save & Restore)
                    | (Save & ~Restore & w_full)
                    | (Restore & ~Save & w_empty);
  assign w_push_idx = r_count[IW-1:0];
  assign w_pop_idx  = r_count[IW-1:0] - IW'(1);

  // Stack payload carries no reset; only the occupancy count is controlled.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_stack[w_push_idx] <= r_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_flags <= w_pop ? r_stack[w_pop_idx] : w_alu_flags;
      if (w_push) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop) begin
        r_count <= r_count - CW'(1);
      end
      r_err <= w_err;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic r_pcsrc;
    logic r_regwrite;
    logic r_memwrite;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_pcsrc    <= 1'b0;
        r_regwrite <= 1'b0;
        r_memwrite <= 1'b0;
      end else begin
        r_pcsrc    <= w_pcsrc;
        r_regwrite <= w_regwrite;
        r_memwrite <= w_memwrite;
      end
    end

    assign PCSrc    = r_pcsrc;
    assign RegWrite = r_regwrite;
    assign MemWrite = r_memwrite;
  end else begin : g_ocomb
    assign PCSrc    = w_pcsrc;
    assign RegWrite = w_regwrite;
    assign MemWrite = w_memwrite;
  end

  assign w_flags_s  = flags_t'(r_flags);
  assign Flags      = {w_flags_s.n, w_flags_s.z, w_flags_s.c, w_flags_s.v};
  assign CondEx     = w_condex;
  assign StackCount = r_count;
  assign StackErr   = r_err;

endmodule
